// File: rtl/wb_j1_pkg.sv
// Shared types and constants for the J1 Wishbone master bridge.
package wb_j1_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/wb_j1_rr_arb.sv
// Combinational two-requester arbiter: fixed (dbus wins) or round-robin on `last`.
module wb_j1_rr_arb
  import wb_j1_pkg::*;
(
  input  logic   ireq,
  input  logic   dreq,
  input  owner_t last,
  input  logic   rr_mode,
  output owner_t grant
);

  always_comb begin
    grant = OWN_D;
    if (ireq && !dreq) begin
      grant = OWN_I;
    end else if (ireq && dreq && rr_mode && (last == OWN_D)) begin
      grant = OWN_I;
    end
  end

endmodule

// File: rtl/wb_j1_master.sv
// Bridges the J1 ibus/dbus onto one registered Wishbone classic master port
// with wait-state, error and timeout termination.
module wb_j1_master
  import wb_j1_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ibus_re,
  input  logic [ADDR_WIDTH-1:0] ibus_adr,
  output logic [DATA_WIDTH-1:0] ibus_dat,
  output logic                  ibus_ack,
  output logic                  ibus_err,
  input  logic                  dbus_re,
  input  logic                  dbus_we,
  input  logic [ADDR_WIDTH-1:0] dbus_adr,
  input  logic [DATA_WIDTH-1:0] dbus_dat_i,
  output logic [DATA_WIDTH-1:0] dbus_dat_o,
  output logic                  dbus_ack,
  output logic                  dbus_err,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack,
  input  logic                  wb_err
);

  // Keep at least one counter bit so TIMEOUT=0 still elaborates.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TimeoutEn = (TIMEOUT != 0);

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  owner_t                  last_q, last_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;

  logic   dreq;
  owner_t grant;
  logic   active, slave_term, timeout, term, err;
  logic [DATA_WIDTH-1:0] rdata;

  assign dreq = dbus_re | dbus_we;

  wb_j1_rr_arb u_arb (
    .ireq    (ibus_re),
    .dreq    (dreq),
    .last    (last_q),
    .rr_mode (1'(ARB_MODE == ARB_RR)),
    .grant   (grant)
  );

  always_comb begin
    active     = (state_q == ACTIVE);
    slave_term = wb_ack | wb_err;
    timeout    = active && TimeoutEn && (cnt_q == CntLast) && !slave_term;
    term       = active && (slave_term || timeout);
    err        = wb_err || timeout;
    rdata      = err ? '0 : wb_dat_i;
  end

  always_comb begin
    ibus_ack   = term && (owner_q == OWN_I);
    dbus_ack   = term && (owner_q == OWN_D);
    ibus_err   = ibus_ack && err;
    dbus_err   = dbus_ack && err;
    ibus_dat   = ibus_ack ? rdata : '0;
    dbus_dat_o = dbus_ack ? rdata : '0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (ibus_re || dreq) begin
          state_d = ACTIVE;
          owner_d = grant;
          last_d  = grant;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          if (grant == OWN_D) begin
            adr_d = dbus_adr;
            we_d  = dbus_we;
            dat_d = dbus_dat_i;
          end else begin
            adr_d = ibus_adr;
            we_d  = 1'b0;
            dat_d = '0;
          end
        end
      end
      ACTIVE: begin
        if (term) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_I;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = we_q;
  assign wb_adr   = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_j1_master.sv
// Directed bench for wb_j1_master: vector table plus contention and reset sequences.
module tb_wb_j1_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_re = 1'b0;
  logic [15:0] ibus_adr = '0;
  logic        dbus_re = 1'b0;
  logic        dbus_we = 1'b0;
  logic [15:0] dbus_adr = '0;
  logic [15:0] dbus_dat_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  // DUT a: round-robin; DUT b: fixed priority. Both share all inputs.
  logic [15:0] a_ibus_dat, a_dbus_dat_o, a_wb_adr, a_wb_dat_o;
  logic        a_ibus_ack, a_ibus_err, a_dbus_ack, a_dbus_err, a_wb_cyc, a_wb_stb, a_wb_we;
  logic [15:0] b_ibus_dat, b_dbus_dat_o, b_wb_adr, b_wb_dat_o;
  logic        b_ibus_ack, b_ibus_err, b_dbus_ack, b_dbus_err, b_wb_cyc, b_wb_stb, b_wb_we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_j1_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ARB_MODE(1), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .ibus_re(ibus_re), .ibus_adr(ibus_adr), .ibus_dat(a_ibus_dat),
    .ibus_ack(a_ibus_ack), .ibus_err(a_ibus_err),
    .dbus_re(dbus_re), .dbus_we(dbus_we), .dbus_adr(dbus_adr), .dbus_dat_i(dbus_dat_i),
    .dbus_dat_o(a_dbus_dat_o), .dbus_ack(a_dbus_ack), .dbus_err(a_dbus_err),
    .wb_cyc(a_wb_cyc), .wb_stb(a_wb_stb), .wb_we(a_wb_we), .wb_adr(a_wb_adr),
    .wb_dat_o(a_wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  wb_j1_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ARB_MODE(0), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .ibus_re(ibus_re), .ibus_adr(ibus_adr), .ibus_dat(b_ibus_dat),
    .ibus_ack(b_ibus_ack), .ibus_err(b_ibus_err),
    .dbus_re(dbus_re), .dbus_we(dbus_we), .dbus_adr(dbus_adr), .dbus_dat_i(dbus_dat_i),
    .dbus_dat_o(b_dbus_dat_o), .dbus_ack(b_dbus_ack), .dbus_err(b_dbus_err),
    .wb_cyc(b_wb_cyc), .wb_stb(b_wb_stb), .wb_we(b_wb_we), .wb_adr(b_wb_adr),
    .wb_dat_o(b_wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  typedef struct {
    string       name;
    logic        ire;
    logic [15:0] iadr;
    logic        dre;
    logic        dwe;
    logic [15:0] dadr;
    logic [15:0] ddat;
    int          waits;
    logic        s_ack;
    logic        s_err;
    logic [15:0] s_dat;
    logic        exp_d;
    logic        exp_we;
    logic        exp_err;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drop_requests();
    ibus_re = 1'b0;
    dbus_re = 1'b0;
    dbus_we = 1'b0;
    wb_ack  = 1'b0;
    wb_err  = 1'b0;
    wb_dat_i = '0;
  endtask

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    ibus_re    = v.ire;
    ibus_adr   = v.iadr;
    dbus_re    = v.dre;
    dbus_we    = v.dwe;
    dbus_adr   = v.dadr;
    dbus_dat_i = v.ddat;
    chk({v.name, " idle cyc"}, a_wb_cyc, 0);
    chk({v.name, " idle ack"}, {a_ibus_ack, a_dbus_ack}, 0);
    @(posedge clk); #1;
    for (int c = 0; c <= v.waits; c++) begin
      // Requester inputs wander mid-cycle; the latched bus must not follow.
      dbus_adr   = ~v.dadr;
      dbus_dat_i = ~v.ddat;
      ibus_adr   = ~v.iadr;
      if (c == v.waits) begin
        wb_ack   = v.s_ack;
        wb_err   = v.s_err;
        wb_dat_i = v.s_dat;
      end
      @(negedge clk);
      chk({v.name, " cyc"}, {a_wb_cyc, a_wb_stb}, 2'b11);
      chk({v.name, " adr"}, a_wb_adr, v.exp_d ? v.dadr : v.iadr);
      chk({v.name, " we"}, a_wb_we, v.exp_we);
      if (v.exp_we) chk({v.name, " dat_o"}, a_wb_dat_o, v.ddat);
      if (c < v.waits) begin
        chk({v.name, " early ack"}, {a_ibus_ack, a_dbus_ack}, 0);
      end else begin
        chk({v.name, " ack"}, {a_ibus_ack, a_dbus_ack}, {!v.exp_d, v.exp_d});
        chk({v.name, " err"}, {a_ibus_err, a_dbus_err}, {!v.exp_d && v.exp_err, v.exp_d && v.exp_err});
        chk({v.name, " rdata"}, v.exp_d ? a_dbus_dat_o : a_ibus_dat, v.exp_dat);
        chk({v.name, " other dat"}, v.exp_d ? a_ibus_dat : a_dbus_dat_o, 0);
      end
      @(posedge clk); #1;
    end
    drop_requests();
    chk({v.name, " cyc drop"}, {a_wb_cyc, a_wb_stb}, 0);
  endtask

  initial begin
    //           name       ire iadr      dre dwe dadr      ddat    w  ack err s_dat     d  we err exp_dat
    vecs[0] = '{"fetch0w",  1, 16'h0123, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'hBEEF, 0, 0, 0, 16'hBEEF};
    vecs[1] = '{"write3w",  0, 16'h0000, 0, 1, 16'h4000, 16'h55AA, 3, 1, 0, 16'h0000, 1, 1, 0, 16'h0000};
    vecs[2] = '{"ackerr",   1, 16'h0200, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h1234, 0, 0, 1, 16'h0000};
    vecs[3] = '{"timeout",  0, 16'h0000, 1, 0, 16'h0800, 16'h0000, 7, 0, 0, 16'hAAAA, 1, 0, 1, 16'h0000};
    vecs[4] = '{"rdwr",     0, 16'h0000, 1, 1, 16'h0ABC, 16'h7777, 1, 1, 0, 16'h0000, 1, 1, 0, 16'h0000};
    vecs[5] = '{"read2w",   0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 2, 1, 0, 16'hCAFE, 1, 0, 0, 16'hCAFE};
    vecs[6] = '{"slverr",   0, 16'h0000, 1, 0, 16'h2468, 16'h0000, 0, 0, 1, 16'hFFFF, 1, 0, 1, 16'h0000};
    vecs[7] = '{"ackat8",   0, 16'h0000, 1, 0, 16'h0F00, 16'h0000, 7, 1, 0, 16'h0F0F, 1, 0, 0, 16'h0F0F};

    // Reset state
    #12;
    chk("rst wb ctl", {a_wb_cyc, a_wb_stb, a_wb_we}, 0);
    chk("rst wb adr/dat", {a_wb_adr, a_wb_dat_o}, 0);
    chk("rst acks", {a_ibus_ack, a_ibus_err, a_dbus_ack, a_dbus_err}, 0);
    chk("rst data", {a_ibus_dat, a_dbus_dat_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention with both requests held: RR alternates from D, fixed always D.
    @(negedge clk);
    ibus_re  = 1'b1;
    ibus_adr = 16'h1111;
    dbus_re  = 1'b1;
    dbus_adr = 16'h2222;
    wb_ack   = 1'b1;
    wb_dat_i = 16'h5A5A;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr grant %0d", k), {a_ibus_ack, a_dbus_ack},
          (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr adr %0d", k), a_wb_adr, (k % 2 == 0) ? 16'h2222 : 16'h1111);
      chk($sformatf("fixed grant %0d", k), {b_ibus_ack, b_dbus_ack}, 2'b01);
      @(posedge clk);
    end
    #1;
    drop_requests();

    foreach (vecs[i]) do_txn(vecs[i]);

    // Reset during the 2nd wait cycle of a dbus read.
    @(negedge clk);
    dbus_re  = 1'b1;
    dbus_adr = 16'h3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid rst pre cyc", a_wb_cyc, 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst cyc", {a_wb_cyc, a_wb_stb, b_wb_cyc}, 0);
    chk("mid rst ack", {a_ibus_ack, a_dbus_ack, b_ibus_ack, b_dbus_ack}, 0);
    drop_requests();
    @(negedge clk);
    chk("mid rst held ack", {a_ibus_ack, a_dbus_ack}, 0);
    rst_n = 1'b1;
    do_txn(vecs[5]);
    do_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_j1_master.md
# wb_j1_master

Wishbone master bridge for the J1 core with wait-state, error and timeout support. It arbitrates the J1 instruction bus (ibus) and data bus (dbus) onto a single registered Wishbone classic master port. Requesters are held until the slave terminates the cycle, which allows slow peripherals and external memory to sit behind the J1 without stalling the fabric forever.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, width of all address ports
- `DATA_WIDTH`, 16, width of all data ports
- `ARB_MODE`, 0, arbitration on contention: 0 = fixed, dbus wins; 1 = round-robin
- `TIMEOUT`, 255, maximum ACTIVE cycles before forced termination; 0 disables the timeout

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ibus_re`  in  1  instruction fetch request, held until `ibus_ack`
- `ibus_adr`  in  ADDR_WIDTH  fetch address
- `ibus_dat`  out  DATA_WIDTH  fetch data, valid with `ibus_ack`
- `ibus_ack`  out  1  fetch terminated
- `ibus_err`  out  1  fetch terminated with error or timeout, qualifies `ibus_ack`
- `dbus_re`, `dbus_we`  in  1  data read / write request, held until `dbus_ack`
- `dbus_adr`  in  ADDR_WIDTH  data address
- `dbus_dat_i`  in  DATA_WIDTH  write data
- `dbus_dat_o`  out  DATA_WIDTH  read data, valid with `dbus_ack`
- `dbus_ack`, `dbus_err`  out  1  same meaning as the ibus pair
- `wb_cyc`, `wb_stb`, `wb_we`  out  1  Wishbone controls, registered
- `wb_adr`  out  ADDR_WIDTH  registered address
- `wb_dat_o`  out  DATA_WIDTH  registered write data
- `wb_dat_i`  in  DATA_WIDTH  slave read data
- `wb_ack`, `wb_err`  in  1  slave termination

## Operation
- The FSM has two states, IDLE and ACTIVE, plus an owner register (I or D) and a round-robin pointer `last`.
- IDLE:
  - A request is present when `ibus_re`, `dbus_re` or `dbus_we` is high.
  - The grant is registered into owner. `wb_adr`, `wb_we` and `wb_dat_o` are latched from the winner. `wb_cyc` and `wb_stb` are set to 1. The state moves to ACTIVE.
- `dbus_we` and `dbus_re` both high: the request is treated as a write.
- Contention with `ARB_MODE`=0: dbus is always granted.
- Contention with `ARB_MODE`=1: the requester that is not `last` is granted. `last` is updated on every grant. After reset, `last` = I, so dbus wins the first tie.
- ACTIVE:
  - Termination occurs on `wb_ack`, `wb_err`, or timeout.
  - On termination, the owner's `*_ack` is asserted combinationally in the same cycle.
  - `*_err` = `wb_err` or timeout. `wb_err` wins over a simultaneous `wb_ack`.
  - Read data = `wb_dat_i` on a normal ack, and 0 on err or timeout.
  - At the terminating edge, `wb_cyc` and `wb_stb` drop and the state returns to IDLE.
- Non-owner `*_ack` and `*_err` are 0. `ibus_dat` and `dbus_dat_o` are 0 when not acked.
- Timeout counter:
  - Width `$clog2(TIMEOUT+1)`. Cleared on entry to ACTIVE and incremented each ACTIVE cycle without termination.
  - When the count equals `TIMEOUT`-1 and there is no slave termination, that cycle is a timeout termination.
- Requester inputs are not re-sampled in ACTIVE. Changes to them mid-cycle are ignored.

## Timing
- Reset (asynchronous, immediate):
  - `wb_cyc`, `wb_stb`, `wb_we` = 0; `wb_adr`, `wb_dat_o` = 0.
  - All `*_ack`, `*_err` and data outputs = 0.
  - State = IDLE, counter = 0, `last` = I.
- Reset mid-cycle drops `wb_cyc` without issuing an ack. The J1 is reset alongside the bridge.
- Latency: a request first seen in IDLE cycle N gives `wb_cyc` high in N+1. With w slave wait states, ack comes in N+1+w. IDLE is reached in N+2+w.
- Throughput: the minimum transfer period is 2 cycles, because every transfer returns through IDLE. The requester drops or changes its request after seeing ack, so IDLE never re-grants a completed request.
- A timeout with `TIMEOUT`=T terminates in the T-th ACTIVE cycle.
- `wb_stb` always equals `wb_cyc`. There are no bursts and no `wb_sel`.

## Structure
- Package `wb_j1_pkg` holds:
  - `state_t` enum {IDLE, ACTIVE}
  - `owner_t` enum {OWN_I, OWN_D}
  - `ARB_FIXED`=0 and `ARB_RR`=1 constants
- Sub-module `wb_j1_rr_arb`: combinational two-requester arbiter. Inputs are the two requests, `last` and the mode; output is the grant.
- The top level holds the FSM, timeout counter, Wishbone registers and the response muxes.

## Test plan
- Zero-wait fetch: `ibus_re`=1, `ibus_adr`=0x0123; slave acks in the first ACTIVE cycle with 0xBEEF. Required: `wb_cyc`=1 and `wb_adr`=0x0123 in N+1; `ibus_ack`=1 and `ibus_dat`=0xBEEF in N+1; `wb_cyc`=0 in N+2.
- Write with 3 wait states: `dbus_we`, adr 0x4000, data 0x55AA. Required: `wb_we`=1 and `wb_dat_o`=0x55AA stable for 4 cycles; `dbus_ack`=1 only in the 4th; `dbus_err`=0.
- Contention, with `ibus_re` and `dbus_re` held continuously:
  - `ARB_MODE`=1: grants D, I, D, I.
  - `ARB_MODE`=0: grants D every time.
- Timeout: `TIMEOUT`=8, slave silent. Required: `dbus_ack`=1, `dbus_err`=1 and `dbus_dat_o`=0 in the 8th ACTIVE cycle; `wb_cyc`=0 the next cycle.
- Simultaneous `wb_ack` and `wb_err` with `wb_dat_i`=0x1234 on an ibus read. Required: `ibus_ack`=1, `ibus_err`=1, `ibus_dat`=0.
- Reset mid-transfer: `rst_n` low during the 2nd wait cycle. Required: `wb_cyc`=0 immediately and no ack. After release, a new request is granted normally.
